// File: rtl/iob_ucb_pkg.sv
// Shared UCB egress definitions: per-target bus widths, serialiser state and
// the index/counter width helper used by the arbiter and the serialiser.
package iob_ucb_pkg;

    localparam int UCB_DRAM_W = 4;
    localparam int UCB_SPI_W  = 4;
    localparam int UCB_CLK_W  = 4;
    localparam int UCB_TAP_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ucb_state_e;

    // Width of a counter/index covering 0..n-1; never narrower than one bit.
    function automatic int ucb_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or above
// ptr, wrapping modulo NCH. Shared by the UCB egress and ingress paths.
module iob_rr_arb
    import iob_ucb_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]              req,
    input  logic [ucb_cnt_w(NCH)-1:0]   ptr,
    output logic [NCH-1:0]              gnt,
    output logic [ucb_cnt_w(NCH)-1:0]   gnt_idx
);

    localparam int IW = ucb_cnt_w(NCH);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NCH; off++) begin
            idx = (int'(ptr) + off) % NCH;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_idx     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/iob_ucb_ser_arb.sv
// IOB-to-UCB egress: round-robin selection among NCH packet sources and
// LSB-first serialisation of each packet onto a stallable BUS_W-bit bus.
module iob_ucb_ser_arb
    import iob_ucb_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int PKT_W = 128,
    parameter int BUS_W = 4
) (
    input  logic                        jbus_gclk,
    input  logic                        jbus_arst_l,
    input  logic [NCH-1:0]              src_vld,
    input  logic [NCH*PKT_W-1:0]        src_data,
    output logic [NCH-1:0]              src_rdy,
    input  logic                        ucb_stall,
    output logic                        ucb_vld,
    output logic [BUS_W-1:0]            ucb_data,
    output logic                        busy,
    output logic [ucb_cnt_w(NCH)-1:0]   cur_src
);

    localparam int NBEAT = PKT_W / BUS_W;
    localparam int IW    = ucb_cnt_w(NCH);
    localparam int CW    = ucb_cnt_w(NBEAT);

    if ((PKT_W % BUS_W) != 0 || NCH < 1 || NBEAT < 1) begin : g_param_err
        $error("iob_ucb_ser_arb: PKT_W must be a non-zero multiple of BUS_W and NCH >= 1");
    end

    ucb_state_e         state, state_nxt;
    logic [CW-1:0]      beat_cnt;
    logic [IW-1:0]      rr_ptr;
    logic [PKT_W-1:0]   shreg;
    logic [PKT_W-1:0]   pkt_sel;
    logic [NCH-1:0]     gnt;
    logic [IW-1:0]      gnt_idx;
    logic               last_beat;
    logic               load_slot;
    logic               any_req;
    logic               take;

    iob_rr_arb #(.NCH(NCH)) u_arb (
        .req     (src_vld),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The last beat's cycle doubles as the next grant slot, so packets abut.
    assign last_beat = (beat_cnt == CW'(NBEAT - 1));
    assign load_slot = !ucb_stall && ((state == IDLE) || (ucb_vld && last_beat));
    assign any_req   = |src_vld;
    assign take      = load_slot && any_req;
    assign pkt_sel   = src_data[int'(gnt_idx)*PKT_W +: PKT_W];
    assign src_rdy   = (load_slot && jbus_arst_l) ? gnt : '0;
    assign busy      = (state == SEND);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take)
                    state_nxt = SEND;
            end
            SEND: begin
                if (load_slot)
                    state_nxt = any_req ? SEND : IDLE;
                else if (ucb_vld && last_beat)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge jbus_gclk or negedge jbus_arst_l) begin
        if (!jbus_arst_l) begin
            state    <= IDLE;
            beat_cnt <= '0;
            rr_ptr   <= '0;
            cur_src  <= '0;
            ucb_vld  <= 1'b0;
            ucb_data <= '0;
        end else begin
            state <= state_nxt;
            if (load_slot) begin
                if (any_req) begin
                    ucb_vld  <= 1'b1;
                    ucb_data <= pkt_sel[BUS_W-1:0];
                    beat_cnt <= '0;
                    cur_src  <= gnt_idx;
                    rr_ptr   <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + IW'(1);
                end else begin
                    ucb_vld  <= 1'b0;
                end
            end else if (state == SEND) begin
                if (ucb_vld) begin
                    // A driven beat is consumed even when a stall is sampled with it.
                    if (last_beat) begin
                        ucb_vld <= 1'b0;
                    end else begin
                        ucb_data <= shreg[BUS_W-1:0];
                        beat_cnt <= beat_cnt + CW'(1);
                        ucb_vld  <= !ucb_stall;
                    end
                end else if (!ucb_stall) begin
                    ucb_vld <= 1'b1;
                end
            end
        end
    end

    // Remaining unsent beats; pure data, reloaded on every grant.
    always_ff @(posedge jbus_gclk) begin
        if (take)
            shreg <= pkt_sel >> BUS_W;
        else if (state == SEND && ucb_vld && !last_beat)
            shreg <= shreg >> BUS_W;
    end

endmodule

// File: tb/tb_iob_ucb_ser_arb.sv
// Bench for iob_ucb_ser_arb: directed scenarios plus randomized traffic, all
// checked against a beat-queue reference model of the egress behaviour.
module tb_iob_ucb_ser_arb;

    localparam int NCH   = 4;
    localparam int PKT_W = 16;
    localparam int BUS_W = 4;
    localparam int NBEAT = PKT_W / BUS_W;

    logic                   jbus_gclk   = 1'b0;
    logic                   jbus_arst_l = 1'b0;
    logic [NCH-1:0]         src_vld     = '0;
    logic [NCH*PKT_W-1:0]   src_data    = '0;
    logic [NCH-1:0]         src_rdy;
    logic                   ucb_stall   = 1'b0;
    logic                   ucb_vld;
    logic [BUS_W-1:0]       ucb_data;
    logic                   busy;
    logic [1:0]             cur_src;

    always #5 jbus_gclk = ~jbus_gclk;

    iob_ucb_ser_arb #(.NCH(NCH), .PKT_W(PKT_W), .BUS_W(BUS_W)) dut (
        .jbus_gclk   (jbus_gclk),
        .jbus_arst_l (jbus_arst_l),
        .src_vld     (src_vld),
        .src_data    (src_data),
        .src_rdy     (src_rdy),
        .ucb_stall   (ucb_stall),
        .ucb_vld     (ucb_vld),
        .ucb_data    (ucb_data),
        .busy        (busy),
        .cur_src     (cur_src)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: beats owed to the receiver, round-robin pointer, source in flight.
    int             exp_q[$];
    int             m_ptr;
    int             m_src;
    bit             exp_vld;
    logic [NCH-1:0] last_gnt;
    int             gnt_log[$];

    task automatic model_reset();
        exp_q.delete();
        m_ptr    = 0;
        m_src    = 0;
        exp_vld  = 1'b0;
        last_gnt = '0;
    endtask

    // Called just after a posedge with this cycle's inputs applied.
    task automatic step();
        logic [NCH-1:0] exp_rdy;
        int g;
        int b;
        @(negedge jbus_gclk);
        chk("busy", busy, 64'(exp_q.size() > 0));
        chk("ucb_vld", ucb_vld, 64'(exp_vld));
        chk("cur_src", cur_src, 64'(m_src));
        if (exp_vld && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            chk("ucb_data", ucb_data, 64'(b));
        end
        exp_rdy = '0;
        g = -1;
        if (!ucb_stall && exp_q.size() == 0) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (g < 0 && src_vld[c]) g = c;
            end
        end
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            for (int k = 0; k < NBEAT; k++)
                exp_q.push_back(int'(src_data[g*PKT_W + k*BUS_W +: BUS_W]));
            m_ptr = (g + 1) % NCH;
            m_src = g;
            gnt_log.push_back(g);
        end
        chk("src_rdy", src_rdy, 64'(exp_rdy));
        exp_vld  = !ucb_stall && (exp_q.size() > 0);
        last_gnt = exp_rdy;
        @(posedge jbus_gclk);
        #1;
    endtask

    task automatic do_reset();
        jbus_arst_l = 1'b0;
        model_reset();
        @(posedge jbus_gclk);
        #1;
        jbus_arst_l = 1'b1;
    endtask

    task automatic drain();
        src_vld   = '0;
        ucb_stall = 1'b0;
        for (int i = 0; i < 40 && (busy || ucb_vld || exp_q.size() > 0); i++)
            step();
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        model_reset();
        // Reset held with all sources requesting.
        src_vld = 4'hF;
        for (int i = 0; i < NCH; i++) src_data[i*PKT_W +: PKT_W] = 16'($urandom);
        repeat (2) @(posedge jbus_gclk);
        @(negedge jbus_gclk);
        chk("rst_ucb_vld", ucb_vld, 0);
        chk("rst_ucb_data", ucb_data, 0);
        chk("rst_src_rdy", src_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_src", cur_src, 0);
        src_vld = '0;
        jbus_arst_l = 1'b1;
        @(posedge jbus_gclk);
        #1;

        // Single packet from source 2.
        src_data[2*PKT_W +: PKT_W] = 16'hA5C3;
        src_vld = 4'b0100;
        step();
        src_vld = '0;
        repeat (5) step();

        // Fairness: all sources held, fresh pointer.
        do_reset();
        gnt_log.delete();
        src_vld = 4'hF;
        for (int i = 0; i < NCH; i++) src_data[i*PKT_W +: PKT_W] = 16'($urandom);
        repeat (22) step();
        chk("rr_cnt", 64'(gnt_log.size() >= 5), 1);
        if (gnt_log.size() >= 5) begin
            chk("rr_order0", gnt_log[0], 0);
            chk("rr_order1", gnt_log[1], 1);
            chk("rr_order2", gnt_log[2], 2);
            chk("rr_order3", gnt_log[3], 3);
            chk("rr_order4", gnt_log[4], 0);
        end
        drain();

        // Stall after beat1 for two sampled cycles.
        src_data[2*PKT_W +: PKT_W] = 16'hA5C3;
        src_vld = 4'b0100;
        step();
        src_vld = '0;
        step();
        ucb_stall = 1'b1;
        step();
        step();
        ucb_stall = 1'b0;
        repeat (4) step();

        // Stall while idle blocks grants.
        ucb_stall = 1'b1;
        src_data[0 +: PKT_W] = 16'h1E7B;
        src_vld = 4'b0001;
        repeat (2) step();
        ucb_stall = 1'b0;
        step();
        drain();

        // Reset mid-packet, then a fresh packet from source 1.
        src_data[1*PKT_W +: PKT_W] = 16'h6D29;
        src_vld = 4'b0010;
        step();
        src_vld = '0;
        repeat (2) step();
        jbus_arst_l = 1'b0;
        #1;
        chk("mid_rst_vld", ucb_vld, 0);
        chk("mid_rst_data", ucb_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdy", src_rdy, 0);
        model_reset();
        @(posedge jbus_gclk);
        #1;
        jbus_arst_l = 1'b1;
        src_data[1*PKT_W +: PKT_W] = 16'h9F04;
        src_vld = 4'b0010;
        step();
        src_vld = '0;
        drain();

        // Randomized traffic with back-pressure and request cancellation.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!src_vld[i] || last_gnt[i]) begin
                    src_vld[i] = ($urandom_range(0, 2) == 0);
                    if (src_vld[i]) src_data[i*PKT_W +: PKT_W] = 16'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    src_vld[i] = 1'b0;
                end
            end
            ucb_stall = ($urandom_range(0, 3) == 0);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
